tlight_guard: RTL

Safety stage directly downstream of the `tlight` controller. It consumes the `ns`/`we` colour outputs, checks them every cycle for illegal encodings, conflicting greens, illegal colour transitions and short yellows, and drives the lamp outputs. The lamps get the controller's colours when the controller behaves. On the first violation the block latches a fault code and forces a fail-safe lamp pattern, which holds until it is cleared.

---
 rtl/tlight_pkg.sv | 29 ++
 rtl/tlight_dwell.sv | 42 ++++
 rtl/tlight_guard.sv | 117 +++++++++++
 3 files changed

// File: rtl/tlight_pkg.sv
// Shared types for the tlight controller and its downstream safety guard.
// Colours are one-hot; anything else on the wire is an encoding fault.
package tlight_pkg;

   typedef enum logic [2:0] {
      RED    = 3'b100,
      YELLOW = 3'b010,
      GREEN  = 3'b001
   } light_t;

   typedef enum logic [1:0] {
      ARM     = 2'd0,
      MONITOR = 2'd1,
      FAULT   = 2'd2
   } guard_state_t;

   typedef enum logic [2:0] {
      NONE     = 3'd0,
      ENC      = 3'd1,
      CONFLICT = 3'd2,
      SEQ      = 3'd3,
      DWELL    = 3'd4
   } fault_code_t;

   function automatic logic is_light(input logic [2:0] c);
      return (c == RED) || (c == YELLOW) || (c == GREEN);
   endfunction

endpackage

// File: rtl/tlight_dwell.sv
// Per-direction history: previous colour and consecutive-yellow counter.
// Flags are raw; the guard decides in which states they count.
module tlight_dwell
   import tlight_pkg::*;
#(
   parameter int MIN_YELLOW = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       run,
   input  logic [2:0] colour,
   output logic       enc_err,
   output logic       seq_err,
   output logic       dwell_err
);

   localparam int CW = $clog2(MIN_YELLOW + 1);

   logic [2:0]    prev_q;
   logic [CW-1:0] ycnt_q;

   // Counter is held at zero while faulted so a fresh yellow count starts in ARM.
   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q <= RED;
         ycnt_q <= '0;
      end else begin
         prev_q <= colour;
         if (!run || colour != YELLOW)
            ycnt_q <= '0;
         else if (ycnt_q != CW'(MIN_YELLOW))
            ycnt_q <= ycnt_q + 1'b1;
      end
   end

   assign enc_err   = !is_light(colour);
   assign seq_err   = (prev_q == RED   && colour == GREEN) ||
                      (prev_q == GREEN && colour == RED);
   assign dwell_err = (prev_q == YELLOW) && (colour != YELLOW) &&
                      (ycnt_q < CW'(MIN_YELLOW));

endmodule

// File: rtl/tlight_guard.sv
// Safety guard after tlight: passes colours through, latches the first fault.
// TLIGHT_GUARD_FLASH_EN selects flashing yellow (and FLASH_HALF) over steady red.
module tlight_guard
   import tlight_pkg::*;
#(
   parameter int MIN_YELLOW = 3
`ifdef TLIGHT_GUARD_FLASH_EN
   , parameter int FLASH_HALF = 4
`endif
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] ns,
   input  logic [2:0] we,
   input  logic       fault_clr,
   output logic [2:0] ns_out,
   output logic [2:0] we_out,
   output logic       fault,
   output logic [2:0] fault_code
);

   logic [1:0][2:0] colour;
   logic [1:0]      enc_err, seq_err, dwell_err;
   logic            run, conflict;
   logic [2:0]      fail_lamp, ns_d, we_d;
   guard_state_t    state_q, state_d;
   fault_code_t     code_q, code_d, det_code;

   assign colour = {ns, we};
   assign run    = (state_q != FAULT);

   for (genvar i = 0; i < 2; i++) begin : g_dir
      tlight_dwell #(.MIN_YELLOW(MIN_YELLOW)) u_dwell (
         .clock     (clock),
         .reset     (reset),
         .run       (run),
         .colour    (colour[i]),
         .enc_err   (enc_err[i]),
         .seq_err   (seq_err[i]),
         .dwell_err (dwell_err[i])
      );
   end

   assign conflict = (ns == GREEN && we != RED) || (we == GREEN && ns != RED);

   // Lowest code wins; history checks only once ARM has captured a sample.
   always_comb begin
      det_code = NONE;
      if (|enc_err)                              det_code = ENC;
      else if (conflict)                         det_code = CONFLICT;
      else if (state_q == MONITOR && |seq_err)   det_code = SEQ;
      else if (state_q == MONITOR && |dwell_err) det_code = DWELL;
   end

`ifdef TLIGHT_GUARD_FLASH_EN
   localparam int FW = $clog2(2 * FLASH_HALF);
   logic [FW-1:0] flash_q, flash_d;

   always_comb begin
      flash_d = '0;
      if (state_q == FAULT && flash_q != FW'(2 * FLASH_HALF - 1))
         flash_d = flash_q + 1'b1;
   end

   assign fail_lamp = (flash_d < FW'(FLASH_HALF)) ? YELLOW : 3'b000;

   always_ff @(posedge clock) begin
      if (reset) flash_q <= '0;
      else       flash_q <= flash_d;
   end
`else
   assign fail_lamp = RED;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ARM;
         ns_out  <= RED;
         we_out  <= RED;
         code_q  <= NONE;
      end else begin
         state_q <= state_d;
         ns_out  <= ns_d;
         we_out  <= we_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARM, MONITOR: state_d = (det_code != NONE) ? FAULT : MONITOR;
         FAULT:        if (fault_clr) state_d = ARM;
         default:      state_d = ARM;
      endcase
   end

   // The violating sample never reaches the lamps: FAULT entry drives fail_lamp.
   always_comb begin
      ns_d   = ns;
      we_d   = we;
      code_d = code_q;
      if (state_d == FAULT) begin
         ns_d = fail_lamp;
         we_d = fail_lamp;
         if (state_q != FAULT) code_d = det_code;
      end else if (state_d == ARM) begin
         ns_d   = RED;
         we_d   = RED;
         code_d = NONE;
      end
   end

   assign fault      = (state_q == FAULT);
   assign fault_code = code_q;

endmodule
